// File: rtl/gb_cpu_common_pkg.sv
// Types and constants shared by the decoder, the sequencer and the datapath.
// A schedule is the decoder's per-instruction plan: one control word per M-cycle.
package gb_cpu_common_pkg;

  localparam int MAX_M_CYCLES = 6;
  localparam int M_CYCLE_W    = $clog2(MAX_M_CYCLES);
  localparam int CNT_W        = $clog2(MAX_M_CYCLES + 1);

  localparam logic [CNT_W-1:0] MAX_CYCLES_CNT = CNT_W'(MAX_M_CYCLES);

  typedef enum logic [1:0] {
    RUN,
    ISR,
    HALT,
    LOCK
  } seq_state_t;

  typedef struct packed {
    logic [3:0] alu_op;
    logic [3:0] reg_sel;
    logic [1:0] addr_sel;
    logic       mem_rd;
    logic       mem_wr;
    logic       pc_inc;
    logic       ir_fetch;
  } m_cycle_ctrl_t;

  localparam m_cycle_ctrl_t IDLE_CTRL = '0;

  typedef struct packed {
    logic [CNT_W-1:0]                   cycles;
    logic [CNT_W-1:0]                   cond_cycle;
    logic                               cb_next;
    logic                               halt;
    logic                               ei;
    logic                               di;
    logic                               reti;
    m_cycle_ctrl_t [MAX_M_CYCLES-1:0]   ctrl;
  } schedule_t;

  function automatic logic [CNT_W-1:0] clamp_cycles(input logic [CNT_W-1:0] cycles);
    return (cycles > MAX_CYCLES_CNT) ? MAX_CYCLES_CNT : cycles;
  endfunction

endpackage

// File: rtl/gb_cpu_ime_ctrl.sv
// Interrupt master enable with the one-instruction EI delay.
// ime_eff is the value the interrupt check at this boundary must see.
module gb_cpu_ime_ctrl (
  input  logic clk,
  input  logic reset,
  input  logic boundary,
  input  logic di,
  input  logic ei,
  input  logic reti,
  input  logic dispatch,
  output logic ime,
  output logic ime_eff
);

  logic ime_q, ime_d, pend_q, pend_d;
  logic ime_n, pend_n;

  // NOTE: every variable gets a default at the top of always_comb, so no path can infer a latch.
  always_comb begin
    ime_n  = ime_q;
    pend_n = pend_q;
    if (boundary) begin
      if (di) begin
        ime_n  = 1'b0;
        pend_n = 1'b0;
      end
      if (reti) ime_n = 1'b1;
      if (ei) begin
        pend_n = 1'b1;
      end else if (pend_n) begin
        ime_n  = 1'b1;
        pend_n = 1'b0;
      end
    end
    ime_eff = ime_n;
    ime_d   = dispatch ? 1'b0 : ime_n;
    pend_d  = pend_n;
  end

  // NOTE: state registers use non-blocking assignments; reset is synchronous, sampled on the clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      ime_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      ime_q  <= ime_d;
      pend_q <= pend_d;
    end
  end

  assign ime = ime_q;

endmodule

// File: rtl/gb_cpu_sequencer.sv
// Steps the decoded schedule one M-cycle at a time and owns the instruction
// boundary: opcode fetch, CB prefix, HALT, lock-up and interrupt dispatch.
module gb_cpu_sequencer
  import gb_cpu_common_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  schedule_t            schedule,
  input  logic                 cond_met,
  input  logic                 int_pending,
  output logic [1:0]           t_cycle,
  output logic [M_CYCLE_W-1:0] m_cycle,
  output m_cycle_ctrl_t        ctrl,
  output logic                 cb_prefix,
  output logic                 isr_cmd,
  output logic                 ir_load,
  output logic                 int_ack,
  output logic                 ime,
  output logic                 halted,
  output logic                 locked
);

  seq_state_t           state_q, state_d;
  logic [1:0]           t_q, t_d;
  logic [M_CYCLE_W-1:0] m_q, m_d, last_m, cond_m;
  logic                 cb_q, cb_d, ir_load_q, ir_load_d, int_ack_q, int_ack_d;
  logic                 illegal, cond_end, is_end, step, boundary, dispatch, ime_eff;

  assign illegal  = (schedule.cycles == '0);
  assign last_m   = M_CYCLE_W'(clamp_cycles(schedule.cycles) - CNT_W'(1));
  assign cond_m   = M_CYCLE_W'(schedule.cond_cycle - CNT_W'(1));
  assign cond_end = (schedule.cond_cycle != '0) && (m_q == cond_m) && !cond_met;
  assign is_end   = illegal || (m_q == last_m) || cond_end;
  assign step     = ((state_q == RUN) || (state_q == ISR)) && (t_q == 2'd3);
  assign boundary = step && is_end && !illegal;

  gb_cpu_ime_ctrl u_ime_ctrl (
    .clk      (clk),
    .reset    (reset),
    .boundary (boundary),
    .di       (schedule.di),
    .ei       (schedule.ei),
    .reti     (schedule.reti),
    .dispatch (dispatch),
    .ime      (ime),
    .ime_eff  (ime_eff)
  );

  always_comb begin
    state_d   = state_q;
    t_d       = (state_q == LOCK) ? 2'd0 : t_q + 2'd1;
    m_d       = m_q;
    cb_d      = cb_q;
    ir_load_d = 1'b0;
    int_ack_d = 1'b0;
    dispatch  = 1'b0;
    case (state_q)
      RUN, ISR: begin
        if (t_q == 2'd3) begin
          if (!is_end) begin
            m_d = m_q + M_CYCLE_W'(1);
          end else begin
            m_d = '0;
            if (illegal) begin
              state_d = LOCK;
            end else if (schedule.cb_next) begin
              // Prefix byte: fetch the real opcode, interrupts wait for it to finish.
              cb_d      = 1'b1;
              ir_load_d = 1'b1;
              state_d   = RUN;
            end else begin
              cb_d = 1'b0;
              if (schedule.halt && !int_pending) begin
                state_d = HALT;
              end else if (ime_eff && int_pending) begin
                state_d   = ISR;
                int_ack_d = 1'b1;
                dispatch  = 1'b1;
              end else begin
                state_d   = RUN;
                ir_load_d = 1'b1;
              end
            end
          end
        end
      end
      HALT: begin
        m_d = '0;
        if (t_q == 2'd3 && int_pending) begin
          if (ime) begin
            state_d   = ISR;
            int_ack_d = 1'b1;
            dispatch  = 1'b1;
          end else begin
            state_d   = RUN;
            ir_load_d = 1'b1;
          end
        end
      end
      LOCK:    m_d = '0;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      t_q       <= 2'd0;
      m_q       <= '0;
      cb_q      <= 1'b0;
      ir_load_q <= 1'b0;
      int_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      m_q       <= m_d;
      cb_q      <= cb_d;
      ir_load_q <= ir_load_d;
      int_ack_q <= int_ack_d;
    end
  end

  assign t_cycle   = t_q;
  assign m_cycle   = m_q;
  assign cb_prefix = cb_q;
  assign ir_load   = ir_load_q;
  assign int_ack   = int_ack_q;
  assign isr_cmd   = (state_q == ISR);
  assign halted    = (state_q == HALT);
  assign locked    = (state_q == LOCK);
  assign ctrl      = (state_q == HALT || state_q == LOCK ||
                      m_q >= M_CYCLE_W'(MAX_M_CYCLES)) ? IDLE_CTRL : schedule.ctrl[m_q];

endmodule

// File: tb/tb_gb_cpu_sequencer.sv
// Bench for gb_cpu_sequencer: a small decoder model feeds schedules, expected
// strobe events go into a queue and a monitor compares them as they appear.
module tb_gb_cpu_sequencer;
  import gb_cpu_common_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  schedule_t            sched;
  logic                 cond_met = 1'b0;
  logic                 int_pending = 1'b0;
  logic [1:0]           t_cycle;
  logic [M_CYCLE_W-1:0] m_cycle;
  m_cycle_ctrl_t        ctrl;
  logic                 cb_prefix, isr_cmd, ir_load, int_ack, ime, halted, locked;

  gb_cpu_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .schedule    (sched),
    .cond_met    (cond_met),
    .int_pending (int_pending),
    .t_cycle     (t_cycle),
    .m_cycle     (m_cycle),
    .ctrl        (ctrl),
    .cb_prefix   (cb_prefix),
    .isr_cmd     (isr_cmd),
    .ir_load     (ir_load),
    .int_ack     (int_ack),
    .ime         (ime),
    .halted      (halted),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    schedule_t s;
    logic      cond;
    logic      ip;
  } instr_t;

  typedef struct {
    string name;
    logic  il;
    logic  ia;
    logic  im;
    logic  cb;
    logic  isr;
    int    gap;
  } exp_t;

  instr_t prog[$];
  exp_t   exp_q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  int     gap_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic schedule_t mk(input int cyc, input int cnd, input logic cb,
                                   input logic hlt, input logic e, input logic d, input logic r);
    schedule_t s;
    s            = '0;
    s.cycles     = CNT_W'(cyc);
    s.cond_cycle = CNT_W'(cnd);
    s.cb_next    = cb;
    s.halt       = hlt;
    s.ei         = e;
    s.di         = d;
    s.reti       = r;
    for (int i = 0; i < MAX_M_CYCLES; i++) begin
      s.ctrl[i].alu_op  = 4'(i + 1);
      s.ctrl[i].reg_sel = 4'(cyc);
      s.ctrl[i].pc_inc  = 1'b1;
    end
    return s;
  endfunction

  schedule_t NOP_S, ISR_S, EI_S, DI_S, CB_S, CBOP_S, JR_S, HALT_S, ILL_S;

  task automatic add(input schedule_t s, input logic c, input logic ip);
    prog.push_back('{s: s, cond: c, ip: ip});
  endtask

  task automatic expect_ev(input string name, input logic il, input logic ia, input logic im,
                           input logic cb, input logic isr, input int gap);
    exp_q.push_back('{name: name, il: il, ia: ia, im: im, cb: cb, isr: isr, gap: gap});
  endtask

  // Decoder model: a new opcode on ir_load, the service schedule on int_ack.
  always begin
    instr_t ins;
    @(negedge clk);
    if (!reset && (ir_load || int_ack)) begin
      if (int_ack) begin
        sched = ISR_S;
      end else if (prog.size() > 0) begin
        ins         = prog.pop_front();
        sched       = ins.s;
        cond_met    = ins.cond;
        int_pending = ins.ip;
      end else begin
        sched = NOP_S;
      end
    end
  end

  // Monitor: compare every strobe with the next expected event.
  always begin
    exp_t       e;
    logic [9:0] st, ex;
    @(posedge clk);
    #1;
    if (reset) begin
      gap_cnt = 0;
    end else begin
      gap_cnt++;
      if (ir_load || int_ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 32'(exp_q.size()), 32'd1);
        end else begin
          e  = exp_q.pop_front();
          st = {ir_load, int_ack, ime, cb_prefix, isr_cmd, halted, locked, m_cycle};
          ex = {e.il, e.ia, e.im, e.cb, e.isr, 1'b0, 1'b0, 3'd0};
          check({e.name, "_status"}, 32'(st), 32'(ex));
          check({e.name, "_gap"}, 32'(gap_cnt), 32'(e.gap));
        end
        gap_cnt = 0;
      end
    end
  end

  task automatic begin_test();
    instr_t ins;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    ins         = prog.pop_front();
    sched       = ins.s;
    cond_met    = ins.cond;
    int_pending = ins.ip;
    reset       = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_pending_events"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    prog.delete();
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    NOP_S  = mk(1, 0, 0, 0, 0, 0, 0);
    ISR_S  = mk(5, 0, 0, 0, 0, 0, 0);
    EI_S   = mk(1, 0, 0, 0, 1, 0, 0);
    DI_S   = mk(1, 0, 0, 0, 0, 1, 0);
    CB_S   = mk(1, 0, 1, 0, 0, 0, 0);
    CBOP_S = mk(4, 0, 0, 0, 0, 0, 0);
    JR_S   = mk(3, 2, 0, 0, 0, 0, 0);
    HALT_S = mk(1, 0, 0, 1, 0, 0, 0);
    ILL_S  = mk(0, 0, 0, 0, 0, 0, 0);
    sched  = NOP_S;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_t_cycle", 32'(t_cycle), 32'd0);
    check("rst_m_cycle", 32'(m_cycle), 32'd0);
    check("rst_flags", 32'({ime, cb_prefix, isr_cmd, ir_load, int_ack, halted, locked}), 32'd0);

    // 1: NOP stream
    repeat (4) add(NOP_S, 1'b0, 1'b0);
    repeat (4) expect_ev("nop", 1, 0, 0, 0, 0, 4);
    begin_test();
    repeat (2) @(negedge clk);
    check("nop_mid_t_cycle", 32'(t_cycle), 32'd2);
    check("nop_mid_m_cycle", 32'(m_cycle), 32'd0);
    drain("nop", 40);

    // 2: conditional JR, false then true
    add(JR_S, 1'b0, 1'b0);
    add(JR_S, 1'b1, 1'b0);
    add(NOP_S, 1'b0, 1'b0);
    expect_ev("jr_false", 1, 0, 0, 0, 0, 8);
    expect_ev("jr_true", 1, 0, 0, 0, 0, 12);
    begin_test();
    repeat (5) @(negedge clk);
    check("jr_m1_index", 32'(m_cycle), 32'd1);
    check("jr_m1_ctrl", 32'(ctrl), 32'(m_cycle_ctrl_t'{alu_op: 4'd2, reg_sel: 4'd3,
          addr_sel: 2'd0, mem_rd: 1'b0, mem_wr: 1'b0, pc_inc: 1'b1, ir_fetch: 1'b0}));
    drain("jr", 60);

    // 3: EI delay, then dispatch after the following NOP
    add(EI_S, 1'b0, 1'b1);
    repeat (3) add(NOP_S, 1'b0, 1'b1);
    expect_ev("ei_end", 1, 0, 0, 0, 0, 4);
    expect_ev("ei_dispatch", 0, 1, 0, 0, 1, 4);
    expect_ev("ei_isr_end", 1, 0, 0, 0, 0, 20);
    expect_ev("ei_after_isr", 1, 0, 0, 0, 0, 4);
    begin_test();
    drain("ei", 80);

    // 4: interrupt deferred across the CB prefix
    add(EI_S, 1'b0, 1'b0);
    add(NOP_S, 1'b0, 1'b0);
    add(CB_S, 1'b0, 1'b1);
    add(CBOP_S, 1'b0, 1'b1);
    add(NOP_S, 1'b0, 1'b0);
    expect_ev("cb_ei", 1, 0, 0, 0, 0, 4);
    expect_ev("cb_ime_on", 1, 0, 1, 0, 0, 4);
    expect_ev("cb_prefix", 1, 0, 1, 1, 0, 4);
    expect_ev("cb_op_dispatch", 0, 1, 0, 0, 1, 16);
    expect_ev("cb_isr_end", 1, 0, 0, 0, 0, 20);
    begin_test();
    drain("cb", 120);

    // 5: HALT with ime=0, woken by int_pending without dispatch
    add(HALT_S, 1'b0, 1'b0);
    expect_ev("halt_wake", 1, 0, 0, 0, 0, 16);
    begin_test();
    repeat (4) @(negedge clk);
    check("halt_entered", 32'(halted), 32'd1);
    check("halt_ctrl_idle", 32'(ctrl), 32'(IDLE_CTRL));
    repeat (10) @(negedge clk);
    check("halt_still", 32'(halted), 32'd1);
    int_pending = 1'b1;
    @(negedge clk);
    check("halt_at_t3", 32'({halted, t_cycle}), 32'({1'b1, 2'd3}));
    drain("halt", 20);

    // 7: EI immediately followed by DI cancels the pending enable
    add(EI_S, 1'b0, 1'b1);
    add(DI_S, 1'b0, 1'b1);
    repeat (2) add(NOP_S, 1'b0, 1'b1);
    expect_ev("eidi_ei", 1, 0, 0, 0, 0, 4);
    expect_ev("eidi_di", 1, 0, 0, 0, 0, 4);
    expect_ev("eidi_nop", 1, 0, 0, 0, 0, 4);
    begin_test();
    drain("eidi", 40);

    // 6: illegal opcode locks up until reset
    add(ILL_S, 1'b0, 1'b0);
    begin_test();
    repeat (6) @(negedge clk);
    check("lock_flag", 32'(locked), 32'd1);
    check("lock_t_cycle", 32'(t_cycle), 32'd0);
    check("lock_ctrl_idle", 32'(ctrl), 32'(IDLE_CTRL));
    repeat (3) @(negedge clk);
    check("lock_t_frozen", 32'({locked, t_cycle}), 32'({1'b1, 2'd0}));
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("lock_reset_flags", 32'({locked, halted, ime, cb_prefix, isr_cmd, ir_load, int_ack}), 32'd0);
    check("lock_reset_counters", 32'({t_cycle, m_cycle}), 32'd0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
